// File: rtl/mcu_pkg.sv
// Shared fetch/dispatch definitions: fetch state encodings, opcode constants
// and instruction field widths used by the fetch controller and its counter.
package mcu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_LATCH,
    S_EXEC,
    S_RETIRE,
    S_HALT
  } fetch_state_t;

  typedef enum logic {
    CTR_DOWN,
    CTR_UP
  } ctr_mode_t;

  localparam int OPCODE_W = 4;
  localparam int PARAM_W  = 6;
  localparam int INSTR_W  = OPCODE_W + 2 * PARAM_W;

  localparam logic [OPCODE_W-1:0] OP_ALU_MIN = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_ALU_MAX = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_HALT    = 4'b1111;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Loadable saturating counter shared by the memory-latency wait (down mode)
// and the EXEC watchdog (up mode).
module fetch_timeout_ctr
  import mcu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  ctr_mode_t        i_mode,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      if (i_mode == CTR_UP) begin
        if (r_count != '1) r_count <= r_count + 1'b1;
      end else begin
        if (r_count != '0) r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_dispatch_fsm.sv
// Instruction fetch/dispatch controller feeding the execution FSMs.
// Optional FETCH_DISPATCH_PERF_EN adds a 16-bit count of done-completed retires.
module fetch_dispatch_fsm
  import mcu_pkg::*;
#(
  parameter int                   MEM_LAT = 2,
  parameter int                   TIMEOUT = 32,
  parameter logic [OPCODE_W-1:0]  HALT_OP = OP_HALT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic [INSTR_W-1:0] i_memData,
  input  logic               i_done,
  output logic               o_pcOutEN,
  output logic               o_marLatch,
  output logic               o_memRead,
  output logic               o_irLatch,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_retired,
  output logic               o_fault,
  output logic               o_halted
`ifdef FETCH_DISPATCH_PERF_EN
  ,
  output logic [15:0]        o_retireCount
`endif
);

  // READ always spends at least one cycle, so MEM_LAT=1 and 2 both load zero
  localparam logic [3:0] WAIT_LOAD = (MEM_LAT > 2) ? 4'(MEM_LAT - 2) : 4'd0;
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  fetch_state_t       r_state;
  fetch_state_t       w_next;
  logic [INSTR_W-1:0] r_ir;
  logic               r_pc_out_en, r_mar_latch, r_mem_read, r_ir_latch;
  logic               r_retired, r_fault, r_halted;
  logic [INSTR_W-1:0] r_instruction;
  logic               w_timeout;
  logic               w_ctr_load, w_ctr_en;
  logic [7:0]         w_ctr_val;
  ctr_mode_t          w_ctr_mode;
  logic [7:0]         w_count;

  fetch_timeout_ctr #(.WIDTH(8)) u_ctr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_ctr_load),
    .i_load_val (w_ctr_val),
    .i_en       (w_ctr_en),
    .i_mode     (w_ctr_mode),
    .o_count    (w_count)
  );

  always_comb begin
    w_ctr_load = 1'b0;
    w_ctr_val  = '0;
    w_ctr_en   = 1'b0;
    w_ctr_mode = CTR_DOWN;
    case (r_state)
      S_ADDR: begin
        w_ctr_load = 1'b1;
        w_ctr_val  = {4'b0000, WAIT_LOAD};
      end
      S_READ:  w_ctr_en = 1'b1;
      S_LATCH: begin
        w_ctr_load = 1'b1;
        w_ctr_mode = CTR_UP;
      end
      S_EXEC: begin
        w_ctr_en   = 1'b1;
        w_ctr_mode = CTR_UP;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:   if (i_run) w_next = S_ADDR;
      S_ADDR:   w_next = S_READ;
      S_READ:   if (w_count == '0) w_next = S_LATCH;
      S_LATCH:  w_next = (opcode_of(i_memData) == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC: begin
        // done wins over a coincident watchdog expiry
        if (i_done) begin
          w_next = S_RETIRE;
        end else if (w_count == TO_LAST) begin
          w_next    = S_RETIRE;
          w_timeout = 1'b1;
        end
      end
      S_RETIRE: w_next = i_run ? S_ADDR : S_IDLE;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_ir          <= '0;
      r_pc_out_en   <= 1'b0;
      r_mar_latch   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_ir_latch    <= 1'b0;
      r_retired     <= 1'b0;
      r_fault       <= 1'b0;
      r_halted      <= 1'b0;
      r_instruction <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LATCH) r_ir <= i_memData;
      if (w_timeout) r_fault <= 1'b1;
      r_pc_out_en   <= (w_next == S_ADDR);
      r_mar_latch   <= (w_next == S_ADDR);
      r_mem_read    <= (w_next == S_READ) || (w_next == S_LATCH);
      r_ir_latch    <= (w_next == S_LATCH);
      r_retired     <= (w_next == S_RETIRE);
      r_halted      <= (w_next == S_HALT);
      r_instruction <= (w_next != S_EXEC) ? '0 :
                       (r_state == S_LATCH) ? i_memData : r_ir;
    end
  end

  assign o_pcOutEN     = r_pc_out_en;
  assign o_marLatch    = r_mar_latch;
  assign o_memRead     = r_mem_read;
  assign o_irLatch     = r_ir_latch;
  assign o_instruction = r_instruction;
  assign o_retired     = r_retired;
  assign o_fault       = r_fault;
  assign o_halted      = r_halted;

`ifdef FETCH_DISPATCH_PERF_EN
  logic        r_timeout_retire;
  logic [15:0] r_retire_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timeout_retire <= 1'b0;
      r_retire_count   <= '0;
    end else begin
      r_timeout_retire <= w_timeout;
      if (r_state == S_RETIRE && !r_timeout_retire) r_retire_count <= r_retire_count + 1'b1;
    end
  end

  assign o_retireCount = r_retire_count;
`endif

endmodule

// File: tb/tb_fetch_dispatch_fsm.sv
// Randomized self-checking bench for fetch_dispatch_fsm with a transaction-level timing model.
module tb_fetch_dispatch_fsm;

  localparam int MEM_LAT = 2;
  localparam int TIMEOUT = 32;
  localparam int READ_CYC = (MEM_LAT > 1) ? MEM_LAT - 1 : 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic        done = 1'b0;
  logic        pc_out_en, mar_latch, mem_read, ir_latch, retired, fault, halted;
  logic [15:0] instruction;
`ifdef FETCH_DISPATCH_PERF_EN
  logic [15:0] retire_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_fault = 1'b0;
  int   exp_retires = 0;

  always #5 clk = ~clk;

  fetch_dispatch_fsm #(.MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT), .HALT_OP(4'b1111)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_run         (run),
    .i_memData     (mem_data),
    .i_done        (done),
    .o_pcOutEN     (pc_out_en),
    .o_marLatch    (mar_latch),
    .o_memRead     (mem_read),
    .o_irLatch     (ir_latch),
    .o_instruction (instruction),
    .o_retired     (retired),
    .o_fault       (fault),
    .o_halted      (halted)
`ifdef FETCH_DISPATCH_PERF_EN
    ,
    .o_retireCount (retire_count)
`endif
  );

  function automatic logic [22:0] ev(input logic pc, input logic mar, input logic rd,
                                     input logic irl, input logic ret, input logic hlt,
                                     input logic [15:0] ins);
    return {pc, mar, rd, irl, ret, exp_fault, hlt, ins};
  endfunction

  // Check this cycle's outputs, then drive the inputs sampled at the edge ending it.
  task automatic tick(input string tag, input logic [22:0] exp, input logic r_run,
                      input logic r_done, input logic [15:0] md, input logic r_rst);
    logic [22:0] got;
    @(negedge clk);
    got = {pc_out_en, mar_latch, mem_read, ir_latch, retired, fault, halted, instruction};
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
    run      = r_run;
    done     = r_done;
    mem_data = md;
    rst      = r_rst;
  endtask

  // One fetch starting with the ADDR cycle; done arrives on EXEC cycle d (none if d > TIMEOUT).
  task automatic fetch(input logic [15:0] md, input int d, input logic run_after);
    int n_exec;
    n_exec = (d <= TIMEOUT) ? d : TIMEOUT;
    tick("addr", ev(1, 1, 0, 0, 0, 0, 16'h0), 1'($urandom), 1'($urandom), 16'($urandom), 1'b0);
    for (int i = 0; i < READ_CYC; i++)
      tick("read", ev(0, 0, 1, 0, 0, 0, 16'h0), 1'($urandom), 1'($urandom), 16'($urandom), 1'b0);
    tick("latch", ev(0, 0, 1, 1, 0, 0, 16'h0), 1'($urandom), 1'($urandom), md, 1'b0);
    for (int k = 1; k <= n_exec; k++)
      tick("exec", ev(0, 0, 0, 0, 0, 0, md), 1'($urandom), (k == d), 16'($urandom), 1'b0);
    if (d > TIMEOUT) exp_fault = 1'b1;
    else exp_retires++;
    tick("retire", ev(0, 0, 0, 0, 1, 0, 16'h0), run_after, 1'($urandom), 16'($urandom), 1'b0);
  endtask

  function automatic logic [15:0] rand_non_halt();
    logic [15:0] v;
    v = 16'($urandom);
    if (v[15:12] == 4'hF) v[12] = 1'b0;
    return v;
  endfunction

  initial begin
    logic ra;
    logic [15:0] zero16;
    zero16 = 16'h0000;

    tick("reset", ev(0, 0, 0, 0, 0, 0, zero16), 1'b0, 1'b0, zero16, 1'b1);
    tick("reset_hold", ev(0, 0, 0, 0, 0, 0, zero16), 1'b0, 1'b1, zero16, 1'b0);
    tick("idle_norun", ev(0, 0, 0, 0, 0, 0, zero16), 1'b0, 1'b1, zero16, 1'b0);
    tick("idle_start", ev(0, 0, 0, 0, 0, 0, zero16), 1'b1, 1'b0, zero16, 1'b0);

    fetch(16'h8042, 9, 1'b1);
    fetch(rand_non_halt(), TIMEOUT, 1'b1);
    fetch(rand_non_halt(), 1, 1'b1);
    fetch(rand_non_halt(), TIMEOUT + 5, 1'b1);

    for (int it = 0; it < 12; it++) begin
      ra = ($urandom_range(0, 3) != 0);
      fetch(rand_non_halt(), int'($urandom_range(1, TIMEOUT + 3)), ra);
      if (!ra) begin
        for (int j = 0; j < int'($urandom_range(0, 3)); j++)
          tick("idle_wait", ev(0, 0, 0, 0, 0, 0, zero16), 1'b0, 1'($urandom), 16'($urandom), 1'b0);
        tick("idle_restart", ev(0, 0, 0, 0, 0, 0, zero16), 1'b1, 1'($urandom), 16'($urandom), 1'b0);
      end
    end

    // Reset in the middle of READ, run held high throughout
    tick("addr_pre_rst", ev(1, 1, 0, 0, 0, 0, zero16), 1'b1, 1'b0, 16'($urandom), 1'b0);
    tick("read_rst", ev(0, 0, 1, 0, 0, 0, zero16), 1'b1, 1'b0, 16'($urandom), 1'b1);
    exp_fault   = 1'b0;
    exp_retires = 0;
    tick("after_rst", ev(0, 0, 0, 0, 0, 0, zero16), 1'b1, 1'b0, 16'($urandom), 1'b0);
    for (int j = 0; j < 3; j++)
      fetch(rand_non_halt(), int'($urandom_range(1, TIMEOUT)), 1'b1);

    tick("addr_halt", ev(1, 1, 0, 0, 0, 0, zero16), 1'b1, 1'b0, 16'($urandom), 1'b0);
`ifdef FETCH_DISPATCH_PERF_EN
    n_tests++;
    assert (retire_count === 16'(exp_retires)) else begin
      n_fail++;
      $error("FAIL retire_count: got %0d, expected %0d", retire_count, exp_retires);
    end
`endif
    for (int i = 0; i < READ_CYC; i++)
      tick("read_halt", ev(0, 0, 1, 0, 0, 0, zero16), 1'b1, 1'b0, 16'($urandom), 1'b0);
    tick("latch_halt", ev(0, 0, 1, 1, 0, 0, zero16), 1'b1, 1'b0, 16'hF000, 1'b0);
    for (int j = 0; j < 5; j++)
      tick("halt", ev(0, 0, 0, 0, 0, 1, zero16), 1'($urandom), 1'($urandom), 16'($urandom), 1'b0);
    tick("halt_rst", ev(0, 0, 0, 0, 0, 1, zero16), 1'b0, 1'b0, zero16, 1'b1);
    exp_fault   = 1'b0;
    exp_retires = 0;
    tick("post_halt_rst", ev(0, 0, 0, 0, 0, 0, zero16), 1'b0, 1'b0, zero16, 1'b0);
    tick("post_halt_idle", ev(0, 0, 0, 0, 0, 0, zero16), 1'b0, 1'b0, zero16, 1'b0);
`ifdef FETCH_DISPATCH_PERF_EN
    n_tests++;
    assert (retire_count === 16'(exp_retires)) else begin
      n_fail++;
      $error("FAIL retire_count_rst: got %0d, expected %0d", retire_count, exp_retires);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_dispatch_fsm.md
Name: fetch_dispatch_fsm

Overview:
Instruction fetch/dispatch controller that sits directly upstream of the ALU control FSM and the other execution FSMs.
- Drives the PC onto the address bus, latches the memory address register, reads program memory and captures the word into the instruction register.
- Presents the captured instruction to the execution FSMs and waits for their done pulse.
- Clears the instruction to 16'h0000 so every execution FSM returns to its idle state, then starts the next fetch.

Parameters:
MEM_LAT, 2, cycles memRead is held before data is valid (1..15)
TIMEOUT, 32, cycles allowed in EXEC before forced retire (2..255)
HALT_OP, 4'b1111, opcode that stops the fetch loop

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  reset, synchronous, active-high
run  in  1  level; 1 = fetch loop enabled
memData  in  16  program memory read data
done  in  1  one-cycle completion pulse from any execution FSM (OR of FSM done outputs)
pcOutEN  out  1  PC drives the address bus
marLatch  out  1  memory address register load strobe
memRead  out  1  program memory read enable
irLatch  out  1  high in the cycle the IR captures memData
instruction  out  16  current instruction to the execution FSMs; 16'h0000 whenever not in EXEC
retired  out  1  one-cycle pulse in the RETIRE cycle
fault  out  1  sticky; set on timeout, cleared only by rst
halted  out  1  high while in HALT

Behaviour:
- Reset values (rst high at a clock edge): state=IDLE, IR=16'h0000, all counters 0, every output 0.
- Outputs are Moore: a function of state only, except that instruction = IR in EXEC.
- States and transitions:
  - IDLE: all strobes 0. If run=1, go to ADDR next cycle.
  - ADDR: pcOutEN=1, marLatch=1 for exactly 1 cycle. Go to READ.
  - READ: memRead=1. Wait counter counts MEM_LAT-1 down to 0, then go to LATCH. READ therefore lasts MEM_LAT-1 cycles; with MEM_LAT=1 it lasts 1 cycle.
  - LATCH: memRead=1, irLatch=1. At the edge ending LATCH, IR <= memData.
    - If memData[15:12]==HALT_OP, go to HALT.
    - Otherwise go to EXEC and clear the timeout counter.
  - EXEC: instruction=IR; the timeout counter increments each cycle.
    - done=1: go to RETIRE.
    - Counter reaches TIMEOUT-1 without done: set fault and go to RETIRE.
    - done and timeout in the same cycle: treat as done; fault is not set.
  - RETIRE: instruction=16'h0000, retired=1 for 1 cycle. Go to ADDR if run=1, otherwise IDLE.
  - HALT: halted=1, instruction=16'h0000. Exit only via rst.
- Fetch latency, measured from the first ADDR cycle to the first EXEC cycle: MEM_LAT+1 cycles.
- run deasserted mid-fetch or in EXEC: the current instruction completes through RETIRE, then the block goes to IDLE. There is no abort.
- done seen outside EXEC is ignored.
- rst asserted in any state returns the block to IDLE on that edge with the IR cleared.
- The block does not increment the PC; pcInc stays owned by the execution FSMs.
- Counter widths: 4-bit wait counter, 8-bit timeout counter. Both saturate and never wrap in normal use.

Optional Feature:
FETCH_DISPATCH_PERF_EN
- Defined: adds output retireCount[15:0].
  - Increments on every RETIRE cycle and wraps 16'hFFFF -> 16'h0000.
  - Resets to 0.
  - Not incremented for timeout retires if fault was set in that same transition.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package (mcu_pkg): fetch state encodings (IDLE, ADDR, READ, LATCH, EXEC, RETIRE, HALT), opcode constants (ALU range 4'b1000..4'b1110, HALT_OP), instruction field widths (opcode 4, param 6/6).
- One sub-module: fetch_timeout_ctr. It is a loadable saturating down/up counter, used for both the MEM_LAT wait and the TIMEOUT watchdog through a mode select.

Test Plan:
- Reset then run=1, memData=16'h8042, MEM_LAT=2 -> pcOutEN/marLatch high 1 cycle; memRead high 2 cycles; instruction=16'h8042 on the 4th cycle after run.
- In EXEC, pulse done 9 cycles in -> retired pulses the next cycle, instruction=16'h0000, then pcOutEN reasserts on the following cycle.
- done never asserted, TIMEOUT=32 -> after 32 EXEC cycles, fault=1 (sticky), retired pulses, fetch continues.
- memData=16'hF000 -> halted=1, instruction=0; run toggles have no effect; rst returns the block to IDLE with halted=0.
- rst asserted mid-READ -> all outputs 0 on the next cycle and IR=0; with run held at 1, fetch restarts cleanly from ADDR.
- FETCH_DISPATCH_PERF_EN defined, 3 completed instructions -> retireCount=3; preload near 16'hFFFF and confirm wrap to 0.
